writeback_stage: RTL

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/titan_pkg.sv | 23 ++
 rtl/writeback_stage_load_formatter.sv | 46 ++++
 rtl/writeback_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/titan_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings,
// FSM state encoding and the context captured for an outstanding load.
package titan_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic       rd_we;
        logic [2:0] funct3;
        logic [1:0] offset;
    } load_ctx_t;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Extracts and extends the addressed byte/halfword/word from an aligned
// 32-bit memory word, flagging misaligned or illegal load encodings.
module load_formatter
    import titan_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        err
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_half = offset[1] ? word[31:16] : word[15:0];
        case (offset)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data = word;
        err  = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU: data = {24'd0, sel_byte};
            F3_LH: begin
                data = {{16{sel_half[15]}}, sel_half};
                err  = offset[0];
            end
            F3_LHU: begin
                data = {16'd0, sel_half};
                err  = offset[0];
            end
            F3_LW:  err = (offset != 2'd0);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results in one cycle and loads after the
// data-memory response, driving the register-file write port and instret.
module writeback_stage
    import titan_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        wb_ready,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_rd_we,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_alu_result,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_data,
    output logic [4:0]  waddr_rd,
    output logic [31:0] wdata_rd,
    output logic        we,
    output logic        load_err,
    output logic [31:0] instret
);

    wb_state_e   state_q, state_d;
    load_ctx_t   ctx_q, ctx_d;
    logic        we_q, we_d;
    logic        load_err_q, load_err_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] instret_q, instret_d;

    logic [31:0] fmt_data;
    logic        fmt_err;
    logic        retire;
    logic        wr_req;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    load_formatter u_load_formatter (
        .word   (dmem_rsp_data),
        .offset (ctx_q.offset),
        .funct3 (ctx_q.funct3),
        .data   (fmt_data),
        .err    (fmt_err)
    );

    assign wb_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d    = state_q;
        ctx_d      = ctx_q;
        load_err_d = 1'b0;
        retire     = 1'b0;
        wr_req     = 1'b0;
        wr_addr    = mem_rd_addr;
        wr_data    = mem_alu_result;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (mem_is_load) begin
                        ctx_d   = '{rd: mem_rd_addr, rd_we: mem_rd_we,
                                    funct3: mem_funct3, offset: mem_alu_result[1:0]};
                        state_d = ST_LOAD_WAIT;
                    end else begin
                        retire = 1'b1;
                        wr_req = mem_rd_we;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                if (dmem_rsp_valid) begin
                    state_d = ST_IDLE;
                    retire  = 1'b1;
                    wr_addr = ctx_q.rd;
                    wr_data = fmt_data;
                    if (fmt_err) begin
                        load_err_d = 1'b1;
                    end else begin
                        wr_req = ctx_q.rd_we;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // x0 is hardwired; the register file never sees a write to it.
        we_d    = wr_req && (wr_addr != 5'd0);
        waddr_d = we_d ? wr_addr : waddr_q;
        wdata_d = we_d ? wr_data : wdata_q;

        instret_d = instret_q + {31'd0, retire};
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ctx_q      <= '0;
            we_q       <= 1'b0;
            load_err_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            ctx_q      <= ctx_d;
            we_q       <= we_d;
            load_err_q <= load_err_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            instret_q  <= instret_d;
        end
    end

    assign we       = we_q;
    assign load_err = load_err_q;
    assign waddr_rd = waddr_q;
    assign wdata_rd = wdata_q;
    assign instret  = instret_q;

endmodule
